// File: rtl/spi_word_tx_if.sv
// ---------------------------------------------------------------------------
// spi_word_tx_if
//   Bundles the word handshake and the serial pins of spi_word_tx.
//
//   Signals:
//     tx_data  [WORD_W]  word to send
//     tx_valid           tx_data valid
//     tx_ready           transmitter can take a word (transfer on valid && ready)
//     sck                serial clock, idles high
//     sdo                serial data, MSB first
//     ss_n               frame select, active low
//     busy               frame in progress (accept .. end of inter-frame gap)
//     done               one-cycle pulse when ss_n returns high
//
//   Modports:
//     master  the transmitter itself (SPI master side, drives the pins)
//     slave   whoever feeds words in and watches the line
// ---------------------------------------------------------------------------
interface spi_word_tx_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              sck;
    logic              sdo;
    logic              ss_n;
    logic              busy;
    logic              done;

    modport master (
        input  tx_data, tx_valid,
        output tx_ready, sck, sdo, ss_n, busy, done
    );

    modport slave (
        output tx_data, tx_valid,
        input  tx_ready, sck, sdo, ss_n, busy, done
    );
endinterface

// File: rtl/spi_word_tx.sv
// ---------------------------------------------------------------------------
// spi_word_tx
//   Host side of the synth's serial control link. Takes parallel command
//   words over a valid/ready handshake and shifts them out MSB first.
//   sck idles high; sdo launches with sck rising, the receiver samples on
//   sck falling. All outputs are registered.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    spi_word_tx_if.master (tx_data, tx_valid, tx_ready, sck, sdo,
//            ss_n, busy, done)
//
//   Parameters:
//     WORD_W   bits per frame (>= 2)
//     CLK_DIV  clk cycles per sck half-period (>= 1)
//     GAP_CYC  clk cycles ss_n stays high between frames (>= 1)
//
//   Build option:
//     SPI_BURST_EN  adds a one-word holding register so consecutive words
//                   are sent inside one ss_n frame with a single done pulse.
// ---------------------------------------------------------------------------
module spi_word_tx #(
    parameter int WORD_W  = 16,
    parameter int CLK_DIV = 10,
    parameter int GAP_CYC = 4
) (
    input  logic          clk,
    input  logic          reset,
    spi_word_tx_if.master bus
);
    // One counter times both the sck half-periods and the inter-frame gap.
    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = $clog2(WORD_W);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic              sck_q, sck_d;
    logic              sdo_q, sdo_d;
    logic              ss_n_q, ss_n_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              phase_end;
    logic              next_go;     // a word is available to start / chain
    logic [WORD_W-1:0] next_word;

    assign accept    = bus.tx_valid && tx_ready_q;
    assign phase_end = (div_cnt_q == DIV_LAST);

`ifdef SPI_BURST_EN
    localparam bit CHAIN = 1'b1;

    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;

    // A held word takes priority; tx_ready is low while it is full, so a
    // fresh accept and a held word never coincide.
    assign next_go   = hold_vld_q || accept;
    assign next_word = hold_vld_q ? hold_q : bus.tx_data;
`else
    localparam bit CHAIN = 1'b0;

    assign next_go   = accept;
    assign next_word = bus.tx_data;
`endif

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        sck_d     = sck_q;
        sdo_d     = sdo_q;
        ss_n_d    = ss_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SPI_BURST_EN
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        // Mid-frame accepts land in the holding register; the start/chain
        // branches below clear it again when they consume the word.
        if (accept) begin
            hold_d     = bus.tx_data;
            hold_vld_d = 1'b1;
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                div_cnt_d = '0;
                sck_d     = 1'b1;
                ss_n_d    = 1'b1;
                if (next_go) begin
                    sh_d      = next_word;
                    sdo_d     = next_word[WORD_W-1];
                    ss_n_d    = 1'b0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SETUP;
`ifdef SPI_BURST_EN
                    hold_vld_d = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                    state_d   = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    sck_d     = 1'b1;
                    if (bit_cnt_q != BIT_LAST) begin
                        // Next bit launches together with the sck rise.
                        sh_d      = sh_q << 1;
                        sdo_d     = sh_q[WORD_W-2];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = S_HIGH;
                    end else if (CHAIN && next_go) begin
                        // Burst: continue straight into the next word
                        // without releasing ss_n.
                        sh_d      = next_word;
                        sdo_d     = next_word[WORD_W-1];
                        bit_cnt_d = '0;
                        state_d   = S_HIGH;
`ifdef SPI_BURST_EN
                        hold_vld_d = 1'b0;
`endif
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                    state_d   = S_LOW;
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    ss_n_d    = 1'b1;
                    sdo_d     = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (div_cnt_q == GAP_LAST) begin
                    div_cnt_d = '0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                div_cnt_d = '0;
                state_d   = S_IDLE;
            end
        endcase

        // tx_ready is computed from next-state values so it is a clean
        // register output with no combinational path from tx_valid.
`ifdef SPI_BURST_EN
        tx_ready_d = !hold_vld_d;
`else
        tx_ready_d = (state_d == S_IDLE);
`endif
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            sck_q      <= 1'b1;
            sdo_q      <= 1'b0;
            ss_n_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_BURST_EN
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            sck_q      <= sck_d;
            sdo_q      <= sdo_d;
            ss_n_q     <= ss_n_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SPI_BURST_EN
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
`endif
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.sck      = sck_q;
    assign bus.sdo      = sdo_q;
    assign bus.ss_n     = ss_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: doc/spi_word_tx.md
Name: spi_word_tx

Overview:
- SPI-style serial word transmitter: the host side of the synth's serial control link (the synth core is the receiver).
- Accepts parallel command words over a valid/ready handshake and serializes them MSB first on sdo, with sck and ss_n.
- Line timing matches the receiver: sck idles high, data launches on sck rising edge, receiver samples on sck falling edge.
- Sits between a control sequencer (or the bench) and the synth core's sdi/sck/ss_n pins.

Parameters:
WORD_W, 16, bits per frame (>=2)
CLK_DIV, 10, clk cycles per sck half-period (>=1)
GAP_CYC, 4, clk cycles ss_n stays high between frames (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tx_data  input  WORD_W  word to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word; transfer occurs on a clk edge where tx_valid && tx_ready
sck  output  1  serial clock; idles high
sdo  output  1  serial data to receiver sdi; MSB first
ss_n  output  1  frame select, active low
busy  output  1  high from accept until GAP ends
done  output  1  one-cycle pulse when ss_n returns high

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values, registered on the next clk edge with reset=1: sck=1, ss_n=1, sdo=0, tx_ready=0, busy=0, done=0, FSM=IDLE, counters=0.
- Reset mid-frame aborts the frame immediately; no done pulse.
- tx_ready rises the first cycle after reset is released.
- All outputs are registered.
- Internal: div_cnt counts 0..CLK_DIV-1; bit_cnt counts 0..WORD_W-1; shift register sh.
- FSM states IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE:
  - outputs: tx_ready=1, ss_n=1, sck=1.
  - On accept: sh<=tx_data, ss_n<=0, sdo<=tx_data[WORD_W-1], bit_cnt<=0, tx_ready<=0, busy<=1, go to SETUP.
- SETUP: after CLK_DIV cycles, sck<=0, go to LOW.
- LOW:
  - After CLK_DIV cycles, sck<=1.
  - If bit_cnt==WORD_W-1, go to HOLD.
  - Else shift sh left, sdo<=next bit, bit_cnt++, go to HIGH.
- HIGH: after CLK_DIV cycles, sck<=0, go to LOW.
- HOLD: after CLK_DIV cycles, ss_n<=1, sdo<=0, done<=1 for one cycle, go to GAP.
- GAP: after GAP_CYC cycles, busy<=0, tx_ready<=1, go to IDLE.
- Frame timing:
  - WORD_W falling sck edges, each mid-bit.
  - Accept to ss_n rise = (2*WORD_W+1)*CLK_DIV cycles; defaults give 330.
  - Accept to next tx_ready = 330 + GAP_CYC = 334.
- sdo changes only:
  - at ss_n fall;
  - coincident with sck rise;
  - at ss_n rise, to 0.
- sdo is never changed at sck fall.
- tx_data/tx_valid are ignored while tx_ready=0; changes after accept do not affect the frame in flight.
- tx_valid held high continuously gives back-to-back frames separated by exactly GAP_CYC+1 cycles of ss_n high (GAP plus the IDLE accept cycle).

Optional Feature:
SPI_BURST_EN
- Defined:
  - One-word holding register; tx_ready=1 whenever the holding register is empty, including during a frame.
  - At the end of the last LOW phase with a held word: sck<=1, sdo<=held MSB, sh<=held word, bit_cnt<=0, go to HIGH.
  - ss_n stays low across words; HOLD/GAP/done occur only after the last word.
  - done pulses once per burst.
- Undefined: behaviour exactly as above; tx_ready is low during the whole frame.

Test Plan:
- Reset held 5 cycles, then released -> sck=1, ss_n=1, sdo=0, busy=0; tx_ready=1 on the first cycle after release.
- Send 16'h01AB, CLK_DIV=10 -> ss_n low for 330 cycles; bits sampled on 16 sck falling edges = 0000_0001_1010_1011; done pulses once; tx_ready returns 4 cycles after ss_n rise.
- tx_valid held high with 16'hA5A5 then 16'h5A5A -> two frames, ss_n high exactly 5 cycles between them; captured words match; tx_data changed mid-frame does not corrupt frame 1.
- Reset asserted at bit 7 of 16'hFFFF -> next edge sck=1, ss_n=1, sdo=0; no done pulse; a new 16'h0001 frame then transmits correctly.
- CLK_DIV=1, WORD_W=2, data 2'b10 -> ss_n low 5 cycles; sck low/high each 1 cycle; samples 1,0.
- SPI_BURST_EN defined, words 16'h1234 and 16'hBEEF offered back-to-back -> ss_n low continuously for 32 sck falls; 32 bits = 1234BEEF; single done pulse.
